multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Control unit for the multicycle RV32I datapath.
- Sequences each instruction through a Moore FSM: fetch, decode, execute, memory and writeback.
- Generates all datapath enables, mux selects and ImmSrc, plus ALUControl from an embedded ALU decoder.
- Successor to the single-cycle decoder:
  - ALUControl width is parametrised, so the 4-bit mode adds xor, sltu, sll, srl and sra.
  - bne is optional.
  - Unsupported encodings trap.
  - A retired-instruction counter is included.

Parameters:
- ALU_W, default 3: ALUControl width. 3 gives the base set only; 4 gives the extended set.
- EN_BNE, default 0: 1 decodes bne (funct3=001 under the branch opcode).
- CNT_W, default 32: width of InstrRet.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- op  in  7  opcode from the instruction register
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register and OldPC enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=RD1
- ALUSrcB  out  2  ALU B select: 00=RD2, 01=ImmExt, 10=4
- ImmSrc  out  2  immediate type: 00=I, 01=S, 10=B, 11=J
- ALUControl  out  ALU_W  ALU operation code
- Trap  out  1  sticky flag: illegal instruction seen
- InstrRet  out  CNT_W  count of completed instructions

Behaviour:
- Clocking and reset
  - Single clock domain; all state updates occur on the rising edge of clk.
  - reset=1 at an edge, including mid-instruction, sets state to FETCH, Trap to 0 and InstrRet to 0.
- Output timing
  - All outputs except PCWrite, ImmSrc and ALUControl are Moore (functions of state only).
  - PCWrite = PCUpdate | (Branch & take), where take = Zero for beq and ~Zero for bne.
  - ImmSrc is combinational on op.
  - Every control signal not listed for a state is 0 in that state.
- States and outputs:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next, by op:
    - lw/sw: MEMADR
    - R-type: EXECUTER
    - I-ALU: EXECUTEI
    - branch: BRANCH
    - jal: JAL
    - anything else: TRAP
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
  - TRAP: all enables 0, Trap=1; the state is absorbing until reset.
- Illegal instruction detection
  - Unsupported funct3 for branch, R-type or I-ALU is detected in DECODE and goes to TRAP.
  - In ALU_W=3 mode, funct3 values 001, 011, 100 and 101 are unsupported.
  - With EN_BNE=0, any branch funct3 other than 000 is unsupported.
- ALU decoder (combinational on ALUOp, funct3, op[5], funct7b5):
  - ALUOp=00 gives add; ALUOp=01 gives sub.
  - ALUOp=10 decodes funct3:
    - 000: sub if op[5]&funct7b5, else add (addi never subtracts).
    - 010: slt
    - 110: or
    - 111: and
    - ALU_W=4 only:
      - 100: xor
      - 011: sltu
      - 001: sll
      - 101: sra if funct7b5, else srl (applies to both R-type and I-type).
  - Encodings for ALU_W=3: add 000, sub 001, and 010, or 011, slt 101.
  - Encodings for ALU_W=4: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, sll 0111, srl 1000, sra 1001.
- InstrRet
  - Increments by 1 at the edge leaving MEMWB, MEMWRITE, ALUWB or BRANCH. JAL counts via ALUWB.
  - Wraps modulo 2^CNT_W and never increments in TRAP.
- Cycles per instruction
  - lw 5; sw 4; R-type 4; I-ALU 4; branch 3; jal 4.

Test Plan:
- lw (op=0000011) after reset → FETCH, DECODE, MEMADR, MEMREAD, MEMWB. MemWrite stays 0; RegWrite=1 only in cycle 5; InstrRet=1.
- R sub (funct3=000, funct7b5=1) → ALUControl=001 in EXECUTER. addi with funct7b5=1 → ALUControl=000.
- beq with Zero=1 → PCWrite=1 in BRANCH; with Zero=0 → PCWrite=0. Each takes 3 cycles.
- With EN_BNE=1, bne with Zero=0 → PCWrite=1. With EN_BNE=0, the same bne → TRAP, Trap=1, InstrRet frozen.
- With ALU_W=4, R funct3=101: funct7b5=1 → ALUControl=1001, funct7b5=0 → 1000. With ALU_W=3 the same instruction → TRAP.
- Pulse reset in MEMREAD → next state FETCH, Trap=0, InstrRet=0. Op=1111111 → TRAP held for 10 cycles.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Moore-FSM control unit for a multicycle RV32I datapath with
//               embedded ALU decoder, illegal-instruction trap and
//               retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int ALU_W  = 3,
    parameter int EN_BNE = 0,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [ALU_W-1:0] ALUControl,
    output logic             Trap,
    output logic [CNT_W-1:0] InstrRet
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] c_OP_LW  = 7'b0000011;
    localparam logic [6:0] c_OP_SW  = 7'b0100011;
    localparam logic [6:0] c_OP_R   = 7'b0110011;
    localparam logic [6:0] c_OP_I   = 7'b0010011;
    localparam logic [6:0] c_OP_BR  = 7'b1100011;
    localparam logic [6:0] c_OP_JAL = 7'b1101111;

    // Extended ALU set present only with a 4-bit ALUControl
    localparam bit c_EXT = (ALU_W >= 4);
    localparam bit c_BNE = (EN_BNE != 0);

    // Base codes are shared by both widths; extended codes only reachable when c_EXT
    localparam logic [ALU_W-1:0] c_ALU_ADD  = ALU_W'(0);
    localparam logic [ALU_W-1:0] c_ALU_SUB  = ALU_W'(1);
    localparam logic [ALU_W-1:0] c_ALU_AND  = ALU_W'(2);
    localparam logic [ALU_W-1:0] c_ALU_OR   = ALU_W'(3);
    localparam logic [ALU_W-1:0] c_ALU_XOR  = ALU_W'(4);
    localparam logic [ALU_W-1:0] c_ALU_SLT  = ALU_W'(5);
    localparam logic [ALU_W-1:0] c_ALU_SLTU = ALU_W'(6);
    localparam logic [ALU_W-1:0] c_ALU_SLL  = ALU_W'(7);
    localparam logic [ALU_W-1:0] c_ALU_SRL  = ALU_W'(8);
    localparam logic [ALU_W-1:0] c_ALU_SRA  = ALU_W'(9);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       w_alu_op;
    logic             w_pc_update;
    logic             w_branch;
    logic             w_take;
    logic             w_alu_f3_ok;
    logic             w_br_f3_ok;
    logic [CNT_W-1:0] r_instr_ret;

    // funct3 legality: the base ALU set covers 000/010/110/111, the extended set all eight
    assign w_alu_f3_ok = c_EXT || (funct3 == 3'b000) || (funct3 == 3'b010) ||
                         (funct3 == 3'b110) || (funct3 == 3'b111);
    assign w_br_f3_ok  = (funct3 == 3'b000) || (c_BNE && (funct3 == 3'b001));

    // bne inverts the sense of Zero; only beq/bne can reach BRANCH
    assign w_take   = funct3[0] ? ~Zero : Zero;
    assign PCWrite  = w_pc_update | (w_branch & w_take);
    assign InstrRet = r_instr_ret;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Retired-instruction counter, bumped when leaving a final state of an instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_ret <= '0;
        end else if ((r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                     (r_state == S_ALUWB) || (r_state == S_BRANCH)) begin
            r_instr_ret <= r_instr_ret + CNT_W'(1);
        end
    end

    // Next-state logic and Moore outputs
    always_comb begin
        w_next      = r_state;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_alu_op    = 2'b00;
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        Trap        = 1'b0;
        case (r_state)
            S_FETCH: begin
                IRWrite     = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                w_pc_update = 1'b1;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_R:           w_next = w_alu_f3_ok ? S_EXECUTER : S_TRAP;
                    c_OP_I:           w_next = w_alu_f3_ok ? S_EXECUTEI : S_TRAP;
                    c_OP_BR:          w_next = w_br_f3_ok ? S_BRANCH : S_TRAP;
                    c_OP_JAL:         w_next = S_JAL;
                    default:          w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b10;
                w_next   = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = 2'b10;
                w_next   = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b01;
                w_branch = 1'b1;
                w_next   = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
                w_next      = S_ALUWB;
            end
            S_TRAP: begin
                Trap   = 1'b1;
                w_next = S_TRAP;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Immediate type straight from the opcode
    always_comb begin
        case (op)
            c_OP_SW:  ImmSrc = 2'b01;
            c_OP_BR:  ImmSrc = 2'b10;
            c_OP_JAL: ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    // ALU decoder
    always_comb begin
        ALUControl = c_ALU_ADD;
        case (w_alu_op)
            2'b01: ALUControl = c_ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000: ALUControl = (op[5] & funct7b5) ? c_ALU_SUB : c_ALU_ADD;
                    3'b010: ALUControl = c_ALU_SLT;
                    3'b110: ALUControl = c_ALU_OR;
                    3'b111: ALUControl = c_ALU_AND;
                    3'b100: if (c_EXT) ALUControl = c_ALU_XOR;
                    3'b011: if (c_EXT) ALUControl = c_ALU_SLTU;
                    3'b001: if (c_EXT) ALUControl = c_ALU_SLL;
                    3'b101: if (c_EXT) ALUControl = funct7b5 ? c_ALU_SRA : c_ALU_SRL;
                    default: ALUControl = c_ALU_ADD;
                endcase
            end
            default: ALUControl = c_ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire
